// File: rtl/fwd_hazard_if.sv
// -----------------------------------------------------------------------------
// Module : fwd_hazard_if
// Purpose: ID-stage operand/hazard signal bundle between ID stage and hazard unit
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface fwd_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             use_rs;
    logic             use_rt;
    logic             id_valid;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_rn;
    logic             flush;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             stall;
    logic             wpcir;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs, rt, use_rs, use_rt, id_valid, id_wreg, id_m2reg, id_rn, flush,
        input  fwda, fwdb, stall, wpcir, stall_cnt
    );

    modport slave (
        input  rs, rt, use_rs, use_rt, id_valid, id_wreg, id_m2reg, id_rn, flush,
        output fwda, fwdb, stall, wpcir, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// Module : fwd_hazard_unit
// Purpose: ID-stage forwarding selects, load-use stall and stall-cycle counter
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  wire logic   clock,
    input  wire logic   reset,
    fwd_hazard_if.slave bus
);

    logic [4:0]       ern;
    logic             ewreg;
    logic             em2reg;
    logic [4:0]       mrn;
    logic             mwreg;
    logic             mm2reg;
    logic [CNT_W-1:0] stall_cnt;

    logic             ex_live;
    logic             mem_live;
    logic             stall;
    logic             capture;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;

    // Register $0 is hardwired, so a write to it never produces a live value.
    assign ex_live  = ewreg && (ern != 5'd0);
    assign mem_live = mwreg && (mrn != 5'd0);

    function automatic logic [1:0] select_for(input logic [4:0] src, input logic used,
                                              input logic e_live, input logic e_load,
                                              input logic [4:0] e_rn,
                                              input logic m_live, input logic m_load,
                                              input logic [4:0] m_rn);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (e_live && !e_load && (e_rn == src)) begin
                sel = 2'b01;
            end else if (m_live && !m_load && (m_rn == src)) begin
                sel = 2'b10;
            end else if (m_live && m_load && (m_rn == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwda = select_for(bus.rs, bus.use_rs, ex_live, em2reg, ern, mem_live, mm2reg, mrn);
        fwdb = select_for(bus.rt, bus.use_rt, ex_live, em2reg, ern, mem_live, mm2reg, mrn);
    end

    // A load still in EX has no data yet; the consumer must wait one cycle.
    assign stall = bus.id_valid && ex_live && em2reg &&
                   ((bus.use_rs && (ern == bus.rs)) || (bus.use_rt && (ern == bus.rt)));

    assign capture = bus.id_valid && !stall && !bus.flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ern    <= 5'd0;
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            mrn    <= 5'd0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
        end else begin
            mrn    <= ern;
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            if (capture) begin
                ern    <= bus.id_rn;
                ewreg  <= bus.id_wreg;
                em2reg <= bus.id_m2reg;
            end else begin
                ern    <= 5'd0;
                ewreg  <= 1'b0;
                em2reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.fwda      = fwda;
    assign bus.fwdb      = fwdb;
    assign bus.stall     = stall;
    assign bus.wpcir     = ~stall;
    assign bus.stall_cnt = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// Module : tb_fwd_hazard_unit
// Purpose: self-checking bench for fwd_hazard_unit (16-bit and 2-bit counters)
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    fwd_hazard_if #(.CNT_W(16)) bus16 ();
    fwd_hazard_if #(.CNT_W(2))  bus2  ();

    assign bus2.rs       = bus16.rs;
    assign bus2.rt       = bus16.rt;
    assign bus2.use_rs   = bus16.use_rs;
    assign bus2.use_rt   = bus16.use_rt;
    assign bus2.id_valid = bus16.id_valid;
    assign bus2.id_wreg  = bus16.id_wreg;
    assign bus2.id_m2reg = bus16.id_m2reg;
    assign bus2.id_rn    = bus16.id_rn;
    assign bus2.flush    = bus16.flush;

    fwd_hazard_unit #(.CNT_W(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
    fwd_hazard_unit #(.CNT_W(2))  dut2  (.clock(clock), .reset(reset), .bus(bus2));

    // Model: the two older in-flight producers, youngest first.
    typedef struct packed {
        logic       live;
        logic       load;
        logic [4:0] rn;
    } prod_t;

    prod_t pipe [2];
    int    stalls;

    function automatic logic [1:0] exp_sel(input logic [4:0] r, input logic used);
        if (!used) return 2'b00;
        if (pipe[0].live && !pipe[0].load && pipe[0].rn == r) return 2'b01;
        if (pipe[1].live && pipe[1].rn == r) return pipe[1].load ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        return bus16.id_valid && pipe[0].live && pipe[0].load &&
               ((bus16.use_rs && bus16.rs == pipe[0].rn) ||
                (bus16.use_rt && bus16.rt == pipe[0].rn));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe[0] = '0;
            pipe[1] = '0;
            stalls  = 0;
        end else begin
            logic st;
            st = exp_stall();
            if (st) stalls++;
            pipe[1] = pipe[0];
            if (bus16.id_valid && !st && !bus16.flush)
                pipe[0] = '{live: bus16.id_wreg && (bus16.id_rn != 5'd0),
                            load: bus16.id_m2reg, rn: bus16.id_rn};
            else
                pipe[0] = '0;
        end
    end

    always @(negedge clock) begin
        logic st;
        st = exp_stall();
        chk("fwda",       {30'd0, bus16.fwda},  {30'd0, exp_sel(bus16.rs, bus16.use_rs)});
        chk("fwdb",       {30'd0, bus16.fwdb},  {30'd0, exp_sel(bus16.rt, bus16.use_rt)});
        chk("stall",      {31'd0, bus16.stall}, {31'd0, st});
        chk("wpcir",      {31'd0, bus16.wpcir}, {31'd0, ~st});
        chk("stall_cnt16", {16'd0, bus16.stall_cnt}, (stalls > 65535) ? 32'd65535 : stalls);
        chk("stall2",     {31'd0, bus2.stall},  {31'd0, st});
        chk("stall_cnt2", {30'd0, bus2.stall_cnt}, (stalls > 3) ? 32'd3 : stalls);
    end

    task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic a_urs, input logic a_urt, input logic a_valid,
                         input logic a_wreg, input logic a_m2reg, input logic [4:0] a_rn,
                         input logic a_flush);
        bus16.rs       = a_rs;
        bus16.rt       = a_rt;
        bus16.use_rs   = a_urs;
        bus16.use_rt   = a_urt;
        bus16.id_valid = a_valid;
        bus16.id_wreg  = a_wreg;
        bus16.id_m2reg = a_m2reg;
        bus16.id_rn    = a_rn;
        bus16.flush    = a_flush;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        drive(5'd3, 5'd7, 1, 1, 1, 1, 1, 5'd3, 0);
        repeat (3) step();
        chk("rst_fwda", {30'd0, bus16.fwda}, 32'd0);
        chk("rst_fwdb", {30'd0, bus16.fwdb}, 32'd0);
        chk("rst_stall", {31'd0, bus16.stall}, 32'd0);
        chk("rst_wpcir", {31'd0, bus16.wpcir}, 32'd1);
        chk("rst_cnt", {16'd0, bus16.stall_cnt}, 32'd0);
        reset = 1'b0;
        drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
        step();
        chk("post_rst_fwda", {30'd0, bus16.fwda}, 32'd0);

        // add $3, then consumers one and two cycles later
        drive(5'd1, 5'd2, 0, 0, 1, 1, 0, 5'd3, 0);
        step();
        drive(5'd3, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0);
        chk("ex_fwd_a", {30'd0, bus16.fwda}, 32'd1);
        step();
        drive(5'd0, 5'd3, 0, 1, 1, 0, 0, 5'd0, 0);
        chk("mem_fwd_b", {30'd0, bus16.fwdb}, 32'd2);
        step();

        // lw $5 then immediate use
        drive(5'd0, 5'd0, 0, 0, 1, 1, 1, 5'd5, 0);
        step();
        drive(5'd5, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0);
        chk("lu_stall", {31'd0, bus16.stall}, 32'd1);
        chk("lu_wpcir", {31'd0, bus16.wpcir}, 32'd0);
        chk("lu_cnt0", {16'd0, bus16.stall_cnt}, 32'd0);
        step();
        chk("lu_resolved", {31'd0, bus16.stall}, 32'd0);
        chk("lu_fwd11", {30'd0, bus16.fwda}, 32'd3);
        chk("lu_cnt1", {16'd0, bus16.stall_cnt}, 32'd1);
        step();

        // add $7, sub $7, then read $7: youngest wins
        drive(5'd0, 5'd0, 0, 0, 1, 1, 0, 5'd7, 0);
        step();
        drive(5'd0, 5'd0, 0, 0, 1, 1, 0, 5'd7, 0);
        step();
        drive(5'd7, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0);
        chk("ex_beats_mem", {30'd0, bus16.fwda}, 32'd1);
        step();

        // $0 is never forwarded and never stalls
        drive(5'd0, 5'd0, 0, 0, 1, 1, 0, 5'd0, 0);
        step();
        drive(5'd0, 5'd0, 1, 1, 1, 0, 0, 5'd0, 0);
        chk("r0_fwda", {30'd0, bus16.fwda}, 32'd0);
        chk("r0_fwdb", {30'd0, bus16.fwdb}, 32'd0);
        step();
        drive(5'd0, 5'd0, 0, 0, 1, 1, 1, 5'd0, 0);
        step();
        drive(5'd0, 5'd0, 1, 1, 1, 0, 0, 5'd0, 0);
        chk("r0_no_stall", {31'd0, bus16.stall}, 32'd0);
        step();

        // flush together with stall: bubble inserted, stall still asserts
        drive(5'd0, 5'd0, 0, 0, 1, 1, 1, 5'd4, 0);
        step();
        drive(5'd4, 5'd0, 1, 0, 1, 1, 0, 5'd6, 1);
        chk("flush_stall", {31'd0, bus16.stall}, 32'd1);
        step();
        drive(5'd4, 5'd6, 1, 1, 1, 0, 0, 5'd0, 0);
        chk("flush_stall_fwd11", {30'd0, bus16.fwda}, 32'd3);
        chk("flush_stall_nocap", {30'd0, bus16.fwdb}, 32'd0);
        step();

        // short pseudo-random sweep over a small register set, model-checked
        for (int i = 0; i < 40; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 5) == 0));
            step();
        end

        // fresh counters, then five load-use stalls on the 2-bit counter
        drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'd0, 0, 0, 1, 1, 1, 5'd5, 0);
            step();
            drive(5'd0, 5'd5, 0, 1, 1, 0, 0, 5'd0, 0);
            chk("sat_stall", {31'd0, bus2.stall}, 32'd1);
            step();
            chk("sat_cnt2", {30'd0, bus2.stall_cnt}, (i < 3) ? i + 1 : 3);
            step();
        end

        // reset mid-stall acts immediately
        drive(5'd0, 5'd0, 0, 0, 1, 1, 1, 5'd5, 0);
        step();
        drive(5'd5, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0);
        chk("pre_rst_stall", {31'd0, bus16.stall}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_stall", {31'd0, bus16.stall}, 32'd0);
        chk("async_rst_cnt16", {16'd0, bus16.stall_cnt}, 32'd0);
        chk("async_rst_cnt2", {30'd0, bus2.stall_cnt}, 32'd0);
        #1;
        reset = 1'b0;
        step();

        // flushed live instruction must never be forwarded
        drive(5'd0, 5'd0, 0, 0, 1, 1, 0, 5'd9, 1);
        step();
        drive(5'd9, 5'd9, 1, 1, 1, 0, 0, 5'd0, 0);
        chk("flush_ex_fwda", {30'd0, bus16.fwda}, 32'd0);
        chk("flush_ex_fwdb", {30'd0, bus16.fwdb}, 32'd0);
        step();
        chk("flush_mem_fwda", {30'd0, bus16.fwda}, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Producer side of the 32-bit 4:1 operand select muxes in the ID stage of the 5-stage pipelined MIPS CPU.
- Keeps its own shadow copy of destination-register state for the EX and MEM stages.
- Generates the 2-bit forwarding selects for operands A and B, the load-use stall, and a saturating stall-cycle counter.
- Sits beside the ID stage; its select outputs drive the select inputs of the operand muxes directly.

Parameters:
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rs  input  5  ID-stage source register A
- rt  input  5  ID-stage source register B
- use_rs  input  1  ID instruction reads rs
- use_rt  input  1  ID instruction reads rt
- id_valid  input  1  ID slot holds a real instruction (0 = bubble)
- id_wreg  input  1  ID instruction writes register file
- id_m2reg  input  1  ID instruction is a load
- id_rn  input  5  ID instruction destination register
- flush  input  1  branch/jump taken; squash ID instruction into EX
- fwda  output  2  operand A select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
- fwdb  output  2  operand B select, same encoding
- stall  output  1  load-use hazard; hold PC and IF/ID
- wpcir  output  1  PC/IR write enable, equals ~stall
- stall_cnt  output  CNT_W  total stall cycles since reset, saturating

Behaviour:
- State registers: ern, ewreg, em2reg (EX shadow); mrn, mwreg, mm2reg (MEM shadow); stall_cnt.
- Reset (async, reset=1): all state registers cleared to 0. With state cleared, the outputs evaluate to fwda=fwdb=00, stall=0, wpcir=1, stall_cnt=0.
- Every rising edge when not in reset:
  - MEM shadow <= EX shadow.
  - EX shadow <= ID inputs (id_rn, id_wreg, id_m2reg) if id_valid=1, stall=0 and flush=0.
  - Otherwise EX shadow is loaded as a bubble (ewreg=0, em2reg=0, ern=0).
- A destination is live only when its wreg bit is 1 and its rn is non-zero. Register $0 is never forwarded and never causes a stall.
- fwda is combinational, zero latency, evaluated in priority order:
  - 01 if EX dest live, not a load, and ern==rs.
  - else 10 if MEM dest live, not a load, and mrn==rs.
  - else 11 if MEM dest live, is a load, and mrn==rs.
  - else 00.
  - When use_rs=0, fwda=00.
  - fwdb is identical using rt and use_rt.
- EX beats MEM when both match the same register (youngest producer wins).
- stall = id_valid & ewreg & em2reg & (ern!=0) & ((use_rs & ern==rs) | (use_rt & ern==rt)).
  - While stall=1, fwda/fwdb are don't-care to the datapath but still follow the same equations.
- A load-use stall lasts exactly one cycle. The bubble moves the load to MEM, where it resolves via select 11.
- flush=1 and stall=1 together: the bubble is inserted and stall still asserts. The flush only suppresses the capture into EX.
- stall_cnt increments by 1 on each edge where stall=1 and saturates at all-ones without wrapping.
- Reset asserted mid-stall clears stall_cnt and the shadows immediately (asynchronous). stall drops in the same cycle.

Test Plan:
- Reset held, arbitrary inputs -> fwda=00, fwdb=00, stall=0, wpcir=1, stall_cnt=0. Release reset -> same until an instruction is issued.
- Issue add $3 (id_wreg=1, id_rn=3). Next cycle ID rs=3, use_rs=1 -> fwda=01. One cycle later rt=3, use_rt=1 -> fwdb=10.
- Issue lw $5. Next cycle ID rs=5, use_rs=1 -> stall=1, wpcir=0, stall_cnt 0->1. Following cycle (same ID held) -> stall=0, fwda=11.
- Issue add $7 followed by sub $7. Third instruction reads rs=7 -> fwda=01 (EX wins over MEM).
- Write to $0, then read rs=0 and rt=0 -> fwda=fwdb=00, stall=0. Also a lw $0 then use $0 -> no stall.
- With CNT_W=2, produce 5 load-use stalls -> stall_cnt sequence 1,2,3,3,3. Assert reset during the next stall -> stall_cnt=0 and stall=0 immediately. A flush cycle with a live ID instruction -> next cycle no forwarding to its rn.
